// File: rtl/fa_4bit_st_if.sv
// Signal bundle for the 4-bit ripple-carry adder: operands in, combinational
// and registered results out.
interface fa_4bit_st_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic       ovf;
  logic [3:0] s_q;
  logic       cout_q;
  logic       ovf_q;

  modport master (
    output a, b, cin,
    input  s, cout, ovf, s_q, cout_q, ovf_q
  );

  modport slave (
    input  a, b, cin,
    output s, cout, ovf, s_q, cout_q, ovf_q
  );
endinterface

// File: rtl/fa_4bit_st.sv
// 4-bit structural ripple-carry adder built from half-adder based full-adder
// cells, with a registered copy of sum, carry-out and signed overflow.
module fa_4bit_st_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_4bit_st_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  fa_4bit_st_ha u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  fa_4bit_st_ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

module fa_4bit_st (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       clk,
  input  logic       rst_n,
  output logic       ovf,
  output logic [3:0] s_q,
  output logic       cout_q,
  output logic       ovf_q
);
  logic [4:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_cell
      fa_4bit_st_cell u_cell (
        .a  (a[i]),
        .b  (b[i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign cout = c[4];
  assign ovf  = c[3] ^ c[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= 4'b0000;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end
endmodule

// File: tb/tb_fa_4bit_st.sv
// Self-checking bench for fa_4bit_st: exhaustive and random sweeps against an
// arithmetic reference, plus directed reset and clock-hold scenarios.
module tb_fa_4bit_st;
  logic clk;
  logic rst_n;
  logic clk_run;
  int   check_count;
  int   error_count;

  logic [5:0] reg_expect;

  fa_4bit_st_if bus ();

  fa_4bit_st dut (
    .s      (bus.s),
    .cout   (bus.cout),
    .a      (bus.a),
    .b      (bus.b),
    .cin    (bus.cin),
    .clk    (clk),
    .rst_n  (rst_n),
    .ovf    (bus.ovf),
    .s_q    (bus.s_q),
    .cout_q (bus.cout_q),
    .ovf_q  (bus.ovf_q)
  );

  // Gated free-running clock so a test can freeze it low.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // Reference: {cout, s, ovf} from plain unsigned and signed arithmetic.
  function automatic logic [5:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
    int usum;
    int sa;
    int sb;
    int ssum;
    logic [4:0] u5;
    usum = int'(a) + int'(b) + int'(cin);
    sa   = a[3] ? int'(a) - 16 : int'(a);
    sb   = b[3] ? int'(b) - 16 : int'(b);
    ssum = sa + sb + int'(cin);
    u5   = usum[4:0];
    return {u5, ((ssum > 7) || (ssum < -8)) ? 1'b1 : 1'b0};
  endfunction

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] comb_now();
    return {2'b00, bus.cout, bus.s, bus.ovf};
  endfunction

  function automatic logic [7:0] reg_now();
    return {2'b00, bus.cout_q, bus.s_q, bus.ovf_q};
  endfunction

  // One 10 ns step: drive at negedge, check comb, then check registers after posedge.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                input string tag);
    logic [5:0] exp_v;
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    exp_v   = ref_model(a, b, cin);
    #1;
    check_output({tag, "_comb"}, comb_now(), {2'b00, exp_v});
    @(posedge clk);
    #1;
    check_output({tag, "_reg"}, reg_now(), {2'b00, exp_v});
    reg_expect = exp_v;
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    clk_run     = 1'b1;
    rst_n       = 1'b0;
    bus.a       = 4'd0;
    bus.b       = 4'd0;
    bus.cin     = 1'b0;
    reg_expect  = 6'd0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_regs", reg_now(), 8'h00);
    check_output("zero_comb", comb_now(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(4'd0,     4'd0,     1'b0, "zero");
    apply_stimulus(4'b0111,  4'b0001,  1'b0, "pos_ovf");
    check_output("pos_ovf_val", comb_now(), {2'b00, 1'b0, 4'b1000, 1'b1});
    apply_stimulus(4'b1000,  4'b1000,  1'b0, "neg_ovf");
    check_output("neg_ovf_val", comb_now(), {2'b00, 1'b1, 4'b0000, 1'b1});
    apply_stimulus(4'd15,    4'd0,     1'b1, "wrap0");
    check_output("wrap0_val", comb_now(), {2'b00, 1'b1, 4'b0000, 1'b0});
    apply_stimulus(4'd15,    4'd15,    1'b1, "max");
    check_output("max_val", {3'b000, bus.cout, bus.s}, {3'b000, 1'b1, 4'b1111});
    check_output("max_reg_val", {3'b000, bus.cout_q, bus.s_q}, {3'b000, 1'b1, 4'b1111});

    // Asynchronous reset between edges; comb path must be untouched.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_regs", reg_now(), 8'h00);
    check_output("async_rst_comb", comb_now(), {2'b00, ref_model(4'd15, 4'd15, 1'b1)});
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_hold_regs", reg_now(), 8'h00);
    bus.a = 4'd6;
    bus.b = 4'd9;
    #1;
    check_output("rst_comb_follow", comb_now(), {2'b00, ref_model(4'd6, 4'd9, 1'b1)});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rst_release_regs", reg_now(), 8'h00);
    @(posedge clk);
    #1;
    check_output("rst_reload", reg_now(), {2'b00, ref_model(4'd6, 4'd9, 1'b1)});
    reg_expect = ref_model(4'd6, 4'd9, 1'b1);

    // Clock frozen low: comb follows inputs, registers hold.
    @(negedge clk);
    clk_run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      bus.a   = ra;
      bus.b   = rb;
      bus.cin = rc;
      #7;
      check_output("hold_comb", comb_now(), {2'b00, ref_model(ra, rb, rc)});
      check_output("hold_regs", reg_now(), {2'b00, reg_expect});
    end
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    check_output("hold_release", reg_now(), {2'b00, ref_model(bus.a, bus.b, bus.cin)});

    // Exhaustive sweep of all 512 input combinations.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          apply_stimulus(4'(ia), 4'(ib), 1'(ic), "sweep");

    // Random sequence.
    for (int k = 0; k < 64; k++)
      apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), "rand");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end
endmodule

// File: doc/fa_4bit_st.md
FA_4BIT_ST -- requirements
Module: fa_4bit_st

Interface
- REQ-001 Parameters: none; the operand width SHALL be fixed at 4 bits.
- REQ-002 clk  input  1  clock; rising edge updates the registered outputs only.
- REQ-003 rst_n  input  1  reset; asynchronous, active-low.
- REQ-004 s  output  4  combinational sum, a+b+cin bits [3:0].
- REQ-005 cout  output  1  combinational carry-out, a+b+cin bit 4.
- REQ-006 a  input  4  unsigned operand A.
- REQ-007 b  input  4  unsigned operand B.
- REQ-008 cin  input  1  carry-in.
- REQ-009 ovf  output  1  combinational two's-complement overflow of a+b+cin.
- REQ-010 s_q  output  4  registered copy of s.
- REQ-011 cout_q  output  1  registered copy of cout.
- REQ-012 ovf_q  output  1  registered copy of ovf.
- REQ-013 Port declaration order SHALL be s, cout, a, b, cin, clk, rst_n, ovf, s_q, cout_q, ovf_q, so a 5-port positional instance (s, cout, a, b, cin) binds correctly.

Function
- REQ-014 {cout, s} SHALL equal a + b + cin as a 5-bit unsigned sum, for all 512 input combinations.
- REQ-015 s and cout SHALL be purely combinational, zero-cycle latency, independent of clk and rst_n.
- REQ-016 The adder SHALL be structural ripple-carry: four 1-bit full-adder cells, each built from two half-adders (XOR/AND) plus an OR for carry.
- REQ-017 Cell i SHALL take a[i], b[i], c[i] and produce s[i], c[i+1]; c[0] = cin; cout = c[4].
- REQ-018 ovf SHALL equal c[3] XOR c[4].
- REQ-019 No behavioural "+" operator SHALL be used for the sum path.
- REQ-020 On each rising clk edge with rst_n high, s_q, cout_q, ovf_q SHALL load the current s, cout, ovf (one-cycle latency).
- REQ-021 Wrap-around: 15+15+1 SHALL give s=4'b1111, cout=1. 15+0+1 SHALL give s=4'b0000, cout=1.
- REQ-022 Outputs SHALL contain no X/Z when all inputs are known.
- REQ-023 A change on any input SHALL propagate to s/cout without requiring a clock edge.

Reset
- REQ-024 When rst_n is low, s_q, cout_q, ovf_q SHALL be 0 immediately, asynchronously to clk.
- REQ-025 While rst_n is low, the registered outputs SHALL hold 0 regardless of clk.
- REQ-026 rst_n SHALL NOT affect s, cout, ovf.
- REQ-027 After rst_n deasserts, the registered outputs SHALL reload on the first rising clk edge.

Verification
- REQ-028 Exhaustive sweep: a, b 0..15, cin 0/1, 10 ns per step -> {cout,s} equals a+b+cin at every step, 512 checks.
- REQ-029 a=0, b=0, cin=0 -> s=0000, cout=0, ovf=0.
- REQ-030 a=4'b0111, b=4'b0001, cin=0 -> s=1000, cout=0, ovf=1. a=4'b1000, b=4'b1000, cin=0 -> s=0000, cout=1, ovf=1.
- REQ-031 a=15, b=15, cin=1 -> s=1111, cout=1. After one clk edge -> s_q=1111, cout_q=1.
- REQ-032 Reset mid-operation: registered outputs nonzero, drop rst_n between clk edges -> s_q, cout_q, ovf_q become 0 at once, while s and cout stay unchanged.
- REQ-033 Inputs change with clk held static -> s and cout follow the inputs; s_q and cout_q do not change until the next rising edge.
